// File: rtl/control_sequencer_pkg.sv
// Purpose: shared types and constants for the fetch/execute/memory control sequencer.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents: state_t encoding, ctrl_flags bit positions, cond_sel codes and the
// condition-match helper used by the branch unit.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Bit positions inside the decoder's ctrl_flags word
    localparam int CF_LDI         = 0;
    localparam int CF_MEM_RE      = 1;
    localparam int CF_MEM_WE      = 2;
    localparam int CF_SPC         = 3;
    localparam int CF_WPC         = 4;
    localparam int CF_IPC         = 5;
    localparam int CF_ADI         = 6;
    localparam int CF_COND        = 7;
    localparam int CF_IMM3        = 8;
    localparam int CF_LUI         = 9;
    localparam int CF_HALT        = 10;
    localparam int CF_COND_SEL_LO = 11;
    localparam int CF_COND_SEL_HI = 12;

    // cond_sel codes; flags[0] = zero, flags[1] = carry
    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_C  = 2'b01;
    localparam logic [1:0] COND_NZ = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    function automatic logic cond_match(input logic [1:0] sel, input logic [1:0] flags);
        logic m;
        case (sel)
            COND_Z:  m = flags[0];
            COND_C:  m = flags[1];
            COND_NZ: m = ~flags[0];
            default: m = ~flags[1];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_sequencer_branch_unit.sv
// Purpose: branch decision and next-PC selection for the EXEC state.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the sequencer decides when next_pc is consumed.
//
// Ports: cond/cond_sel/flags choose whether the branch is taken; wpc jumps to
// alu_out (halfword index alu_out[PC_W:1]); ipc adds sext(imm[IMM_W-1:1]) to pc,
// where pc is already the incremented PC. wpc wins over ipc. next_pc = pc otherwise.
module branch_unit
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int PC_W  = XLEN - 1,
    parameter int IMM_W = 8
) (
    input  logic             cond,
    input  logic [1:0]       cond_sel,
    input  logic [1:0]       flags,
    input  logic             wpc,
    input  logic             ipc,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic [PC_W-1:0]  next_pc
);

    // imm[0] is dropped: the offset is in halfwords
    logic [PC_W-1:0] rel_off;
    logic            unused_bits;

    assign taken       = ~cond | cond_match(cond_sel, flags);
    assign rel_off     = {{(PC_W - IMM_W + 1){imm[IMM_W-1]}}, imm[IMM_W-1:1]};
    assign unused_bits = ^{alu_out[0], imm[0]};

    always_comb begin
        next_pc = pc;
        if (taken && wpc) begin
            next_pc = alu_out[PC_W:1];
        end else if (taken && ipc) begin
            next_pc = pc + rel_off;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: FETCH -> EXEC -> optional MEM control sequencer with sticky HALT.
// Latency: 2 cycles per ALU/branch instruction at zero wait, +1 per memory wait state.
// Backpressure: FETCH and MEM stall with no side effects until mem_ready; EXEC ignores it.
//
// Ports: clk/rst (async, active-high); ctrl_flags/flags from decoder and ALU;
// reg_o0/reg_o2/alu_out/mem_rdata data inputs; mem_req/mem_we/mem_addr/mem_wdata/
// mem_byte_half to the unified memory port; inst, reg_in/reg_we, alu_b, pc, halted.
// All outputs except pc/inst are combinational from state and inputs, so rst
// silences mem_req/reg_we in the same cycle it is asserted.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter int              PC_W     = XLEN - 1,
    parameter int              IMM_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     ctrl_flags,
    input  logic [1:0]      flags,
    input  logic [XLEN-1:0] reg_o0,
    input  logic [XLEN-1:0] reg_o2,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_byte_half,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] reg_in,
    output logic            reg_we,
    output logic [XLEN-1:0] alu_b,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t state;

    logic             cf_ldi, cf_re, cf_we, cf_spc, cf_wpc, cf_ipc;
    logic             cf_adi, cf_cond, cf_imm3, cf_lui, cf_halt;
    logic [1:0]       cf_cond_sel;
    logic [IMM_W-1:0] imm;
    logic [XLEN-1:0]  link_addr;
    logic [PC_W-1:0]  br_next_pc;
    logic             br_taken;
    logic             unused_bits;

    assign cf_ldi      = ctrl_flags[CF_LDI];
    assign cf_re       = ctrl_flags[CF_MEM_RE];
    assign cf_we       = ctrl_flags[CF_MEM_WE];
    assign cf_spc      = ctrl_flags[CF_SPC];
    assign cf_wpc      = ctrl_flags[CF_WPC];
    assign cf_ipc      = ctrl_flags[CF_IPC];
    assign cf_adi      = ctrl_flags[CF_ADI];
    assign cf_cond     = ctrl_flags[CF_COND];
    assign cf_imm3     = ctrl_flags[CF_IMM3];
    assign cf_lui      = ctrl_flags[CF_LUI];
    assign cf_halt     = ctrl_flags[CF_HALT];
    assign cf_cond_sel = ctrl_flags[CF_COND_SEL_HI:CF_COND_SEL_LO];

    assign imm       = inst[IMM_W-1:0];
    // pc has already been incremented by FETCH, so this is the return address
    assign link_addr = XLEN'({pc, 1'b0});

    assign unused_bits = ^{ctrl_flags[15:13], inst[XLEN-1:IMM_W], reg_o0[XLEN-1:XLEN-IMM_W], br_taken};

    branch_unit #(
        .XLEN  (XLEN),
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_branch (
        .cond     (cf_cond),
        .cond_sel (cf_cond_sel),
        .flags    (flags),
        .wpc      (cf_wpc),
        .ipc      (cf_ipc),
        .alu_out  (alu_out),
        .imm      (imm),
        .pc       (pc),
        .taken    (br_taken),
        .next_pc  (br_next_pc)
    );

    // ---------------- memory port ----------------
    assign mem_req       = ~rst & ((state == ST_FETCH) | (state == ST_MEM));
    assign mem_we        = ~rst & (state == ST_MEM) & cf_we;
    assign mem_addr      = (state == ST_MEM) ? alu_out : link_addr;
    assign mem_wdata     = reg_o0;
    assign mem_byte_half = (state == ST_MEM) ? inst[3] : 1'b1;
    assign halted        = ~rst & (state == ST_HALT);

    // Load write-back only on the ready cycle; a simultaneous store suppresses it
    assign reg_we = ~rst & (((state == ST_EXEC) & ~cf_halt & ~cf_re & ~cf_we) |
                            ((state == ST_MEM) & mem_ready & cf_re & ~cf_we));

    always_comb begin
        reg_in = alu_out;
        if (state == ST_MEM) begin
            reg_in = mem_rdata;
        end else if (cf_spc) begin
            reg_in = link_addr;
        end else if (cf_ldi) begin
            reg_in = {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
        end else if (cf_lui) begin
            reg_in = {imm, reg_o0[XLEN-IMM_W-1:0]};
        end
    end

    always_comb begin
        alu_b = reg_o2;
        if (cf_adi) begin
            alu_b = {{(XLEN - 4){inst[3]}}, inst[3:0]};
        end else if (cf_imm3) begin
            alu_b = {{(XLEN - 3){1'b0}}, inst[2:0]};
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        inst  <= mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cf_halt) begin
                        state <= ST_HALT;
                    end else if (cf_re || cf_we) begin
                        state <= ST_MEM;
                    end else begin
                        pc    <= br_next_pc;
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_r = 1'b1;
    logic [15:0] ctrl_flags = '0;
    logic [1:0]  flags = '0;
    logic [15:0] reg_o0 = '0;
    logic [15:0] reg_o2 = '0;
    logic [15:0] alu_out = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, mem_byte_half, reg_we, halted;
    logic [15:0] mem_addr, mem_wdata, inst, reg_in, alu_b;
    logic [14:0] pc;

    logic        mem_req_r, mem_we_r, mem_byte_half_r, reg_we_r, halted_r;
    logic [15:0] mem_addr_r, mem_wdata_r, inst_r, reg_in_r, alu_b_r;
    logic [14:0] pc_r;

    int tests = 0;
    int fails = 0;
    int we_pulses = 0;
    int pulse_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (reg_we === 1'b1) we_pulses <= we_pulses + 1;

    control_sequencer #(.XLEN(16), .PC_W(15), .IMM_W(8), .RESET_PC(15'h0000)) u_dut (
        .clk(clk), .rst(rst), .ctrl_flags(ctrl_flags), .flags(flags),
        .reg_o0(reg_o0), .reg_o2(reg_o2), .alu_out(alu_out), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_half(mem_byte_half), .inst(inst),
        .reg_in(reg_in), .reg_we(reg_we), .alu_b(alu_b), .pc(pc), .halted(halted)
    );

    control_sequencer #(.XLEN(16), .PC_W(15), .IMM_W(8), .RESET_PC(15'h0100)) u_dut_r (
        .clk(clk), .rst(rst_r), .ctrl_flags(ctrl_flags), .flags(flags),
        .reg_o0(reg_o0), .reg_o2(reg_o2), .alu_out(alu_out), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req_r), .mem_we(mem_we_r), .mem_addr(mem_addr_r),
        .mem_wdata(mem_wdata_r), .mem_byte_half(mem_byte_half_r), .inst(inst_r),
        .reg_in(reg_in_r), .reg_we(reg_we_r), .alu_b(alu_b_r), .pc(pc_r), .halted(halted_r)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] ctrl;
        logic [15:0] iw;
        logic [1:0]  fl;
        logic [15:0] alu;
        logic [15:0] o0;
        logic [15:0] o2;
        logic        we;
        logic [15:0] rin;
        logic [15:0] alub;
        logic [14:0] npc;
    } vec_t;

    vec_t vq[$];

    initial begin
        // ctrl, inst word, flags, alu_out, reg_o0, reg_o2 | reg_we, reg_in, alu_b, pc after EXEC
        vq.push_back('{16'h0001, 16'h0080, 2'b00, 16'h1357, 16'h0000, 16'h1111, 1'b1, 16'hFF80, 16'h1111, 15'h0001}); // ldi
        vq.push_back('{16'h0200, 16'h00AB, 2'b00, 16'h1357, 16'h12CD, 16'h2222, 1'b1, 16'hABCD, 16'h2222, 15'h0002}); // lui
        vq.push_back('{16'h0140, 16'h000E, 2'b00, 16'h5555, 16'h0000, 16'h3333, 1'b1, 16'h5555, 16'hFFFE, 15'h0003}); // adi over imm3
        vq.push_back('{16'h10A0, 16'h00FA, 2'b00, 16'h0A0A, 16'h0000, 16'h4444, 1'b1, 16'h0A0A, 16'h4444, 15'h0001}); // ipc NZ taken, 4-3
        vq.push_back('{16'h0100, 16'h000D, 2'b00, 16'h0777, 16'h0000, 16'h5555, 1'b1, 16'h0777, 16'h0005, 15'h0002}); // imm3
        vq.push_back('{16'h18A0, 16'h0004, 2'b10, 16'h0001, 16'h0000, 16'h6666, 1'b1, 16'h0001, 16'h6666, 15'h0003}); // ipc NC not taken
        vq.push_back('{16'h10A0, 16'h00FA, 2'b01, 16'h0002, 16'h0000, 16'h7777, 1'b1, 16'h0002, 16'h7777, 15'h0004}); // ipc NZ not taken
        vq.push_back('{16'h08A0, 16'h0004, 2'b10, 16'h0003, 16'h0000, 16'h8888, 1'b1, 16'h0003, 16'h8888, 15'h0007}); // ipc C taken, 5+2
        vq.push_back('{16'h00A0, 16'h00FE, 2'b00, 16'h0004, 16'h0000, 16'h9999, 1'b1, 16'h0004, 16'h9999, 15'h0008}); // ipc Z not taken
        vq.push_back('{16'h0020, 16'h0002, 2'b11, 16'h0005, 16'h0000, 16'hAAAA, 1'b1, 16'h0005, 16'hAAAA, 15'h000A}); // ipc uncond, 9+1
        vq.push_back('{16'h0030, 16'h0002, 2'b00, 16'h0030, 16'h0000, 16'hBBBB, 1'b1, 16'h0030, 16'hBBBB, 15'h0018}); // wpc beats ipc
        vq.push_back('{16'h0010, 16'h0000, 2'b00, 16'h001E, 16'h0000, 16'hCCCC, 1'b1, 16'h001E, 16'hCCCC, 15'h000F}); // wpc
        vq.push_back('{16'h0018, 16'h0000, 2'b00, 16'h0120, 16'h0000, 16'hDDDD, 1'b1, 16'h0020, 16'hDDDD, 15'h0090}); // wpc+spc link
        vq.push_back('{16'h0010, 16'h0000, 2'b00, 16'hFFFE, 16'h0000, 16'hEEEE, 1'b1, 16'hFFFE, 16'hEEEE, 15'h7FFF}); // wpc to top
        vq.push_back('{16'h0000, 16'h0000, 2'b00, 16'h0042, 16'h0000, 16'h0101, 1'b1, 16'h0042, 16'h0101, 15'h0000}); // pc wraps
        vq.push_back('{16'h0090, 16'h0000, 2'b00, 16'h0100, 16'h0000, 16'h0202, 1'b1, 16'h0100, 16'h0202, 15'h0001}); // cond wpc not taken
        vq.push_back('{16'h0009, 16'h0080, 2'b00, 16'h0000, 16'h0000, 16'h0303, 1'b1, 16'h0004, 16'h0303, 15'h0002}); // spc over ldi
        vq.push_back('{16'h0201, 16'h0005, 2'b00, 16'h0000, 16'h00FF, 16'h0404, 1'b1, 16'h0005, 16'h0404, 15'h0003}); // ldi over lui

        // Reset state
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_inst", inst, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait instructions from the table
        foreach (vq[i]) begin
            @(negedge clk);
            ctrl_flags = '0;
            mem_ready  = 1'b1;
            mem_rdata  = vq[i].iw;
            #1;
            chk($sformatf("v%0d_fetch_addr", i), mem_addr, {pc, 1'b0});
            @(negedge clk);
            ctrl_flags = vq[i].ctrl;
            flags      = vq[i].fl;
            alu_out    = vq[i].alu;
            reg_o0     = vq[i].o0;
            reg_o2     = vq[i].o2;
            mem_rdata  = 16'hDEAD;
            #1;
            chk($sformatf("v%0d_inst", i), inst, vq[i].iw);
            chk($sformatf("v%0d_mem_req", i), mem_req, 0);
            chk($sformatf("v%0d_reg_we", i), reg_we, vq[i].we);
            chk($sformatf("v%0d_reg_in", i), reg_in, vq[i].rin);
            chk($sformatf("v%0d_alu_b", i), alu_b, vq[i].alub);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, vq[i].npc);
        end

        // Load with wait states in FETCH and MEM
        @(negedge clk);
        pulse_base = we_pulses;
        ctrl_flags = '0;
        mem_ready  = 1'b0;
        mem_rdata  = 16'h0008;
        repeat (3) begin
            #1;
            chk("fw_req", mem_req, 1);
            chk("fw_addr", mem_addr, 16'h0006);
            chk("fw_pc", pc, 3);
            chk("fw_inst", inst, 16'h0005);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        ctrl_flags = 16'h0002;
        mem_ready  = 1'b0;
        alu_out    = 16'h0044;
        mem_rdata  = 16'h1111;
        #1;
        chk("ld_exec_we", reg_we, 0);
        chk("ld_exec_inst", inst, 16'h0008);
        @(negedge clk);
        repeat (3) begin
            #1;
            chk("mw_req", mem_req, 1);
            chk("mw_addr", mem_addr, 16'h0044);
            chk("mw_we", mem_we, 0);
            chk("mw_half", mem_byte_half, 1);
            chk("mw_reg_we", reg_we, 0);
            chk("mw_inst", inst, 16'h0008);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("ld_reg_we", reg_we, 1);
        chk("ld_reg_in", reg_in, 16'hBEEF);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("ld_next_fetch", mem_addr, 16'h0008);
        chk("ld_next_we", reg_we, 0);
        chk("ld_pulses", we_pulses - pulse_base, 1);

        // Store (with mem_re also set) then halt
        mem_ready = 1'b1;
        mem_rdata = 16'h0000;
        @(negedge clk);
        ctrl_flags = 16'h0006;
        reg_o0     = 16'h1234;
        alu_out    = 16'h0040;
        mem_ready  = 1'b0;
        #1;
        chk("st_exec_we", reg_we, 0);
        chk("st_exec_req", mem_req, 0);
        @(negedge clk);
        repeat (2) begin
            #1;
            chk("sw_mem_we", mem_we, 1);
            chk("sw_wdata", mem_wdata, 16'h1234);
            chk("sw_addr", mem_addr, 16'h0040);
            chk("sw_half", mem_byte_half, 0);
            chk("sw_reg_we", reg_we, 0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("st_rdy_mem_we", mem_we, 1);
        chk("st_rdy_reg_we", reg_we, 0);
        @(negedge clk);
        mem_rdata = 16'h4C5A;
        #1;
        chk("st_next_mem_we", mem_we, 0);
        chk("st_next_addr", mem_addr, 16'h000A);
        @(negedge clk);
        ctrl_flags = 16'h0409;
        #1;
        chk("halt_exec_we", reg_we, 0);
        chk("halt_exec_halted", halted, 0);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            mem_ready = k[0];
            ctrl_flags = k[0] ? 16'h0000 : 16'h0409;
            #1;
            chk($sformatf("h%0d_halted", k), halted, 1);
            chk($sformatf("h%0d_req", k), mem_req, 0);
            chk($sformatf("h%0d_we", k), reg_we, 0);
            chk($sformatf("h%0d_pc", k), pc, 6);
            chk($sformatf("h%0d_inst", k), inst, 16'h4C5A);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a MEM access (RESET_PC = 0x100)
        ctrl_flags = '0;
        #1;
        chk("r_hold_req", mem_req_r, 0);
        chk("r_hold_we", reg_we_r, 0);
        chk("r_hold_halted", halted_r, 0);
        chk("r_hold_pc", pc_r, 15'h0100);
        @(negedge clk);
        rst_r     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'h0000;
        #1;
        chk("r_fetch_req", mem_req_r, 1);
        chk("r_fetch_addr", mem_addr_r, 16'h0200);
        @(negedge clk);
        ctrl_flags = 16'h0002;
        mem_ready  = 1'b0;
        alu_out    = 16'h0050;
        #1;
        chk("r_exec_pc", pc_r, 15'h0101);
        @(negedge clk);
        #1;
        chk("r_mem_req", mem_req_r, 1);
        chk("r_mem_addr", mem_addr_r, 16'h0050);
        #1;
        rst_r = 1'b1;
        #1;
        chk("r_async_req", mem_req_r, 0);
        chk("r_async_we", reg_we_r, 0);
        chk("r_async_pc", pc_r, 15'h0100);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("r_async_we_rdy", reg_we_r, 0);
        @(negedge clk);
        #1;
        chk("r_held_we", reg_we_r, 0);
        @(negedge clk);
        rst_r = 1'b0;
        #1;
        chk("r_post_req", mem_req_r, 1);
        chk("r_post_addr", mem_addr_r, 16'h0200);
        chk("r_post_half", mem_byte_half_r, 1);
        chk("r_post_inst", inst_r, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised successor to the two-phase fetch/execute control unit of the 16-bit core. It sequences FETCH → EXEC → optional MEM through an explicit state machine. It adds a memory ready handshake (multi-cycle memories), PC-relative immediate branches, a well-defined four-way condition select, and a sticky HALT state. It sits between the decoder (ctrl_flags), register file, ALU and the unified instruction/data memory port.

Parameters:
XLEN, 16, datapath/instruction width
PC_W, XLEN-1, halfword-aligned PC width; byte address = {pc, 1'b0}
IMM_W, 8, immediate field width, taken from inst[IMM_W-1:0]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ctrl_flags  in  16  decoded control word. Bit map: [0] ldi, [1] mem_re, [2] mem_we, [3] spc, [4] wpc, [5] ipc, [6] adi, [7] cond, [8] imm3, [9] lui, [10] halt, [12:11] cond_sel
flags  in  2  ALU status: [0] zero, [1] carry
reg_o0, reg_o2  in  XLEN  register file read ports (o0 = store data / lui low byte, o2 = ALU B source)
alu_out  in  XLEN  ALU result / effective address / jump target
mem_rdata  in  XLEN  memory read data
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  write strobe (qualified by mem_req)
mem_addr  out  XLEN  byte address
mem_wdata  out  XLEN  = reg_o0
mem_byte_half  out  1  1 = halfword access, 0 = byte
inst  out  XLEN  latched instruction
reg_in  out  XLEN  register write data
reg_we  out  1  register write enable
alu_b  out  XLEN  ALU B operand
pc  out  PC_W  current PC
halted  out  1  core stopped

Behaviour:
- States: FETCH, EXEC, MEM, HALT. All outputs are combinational from state/inputs, so rst forces them immediately.
- Reset (async): state=FETCH, pc=RESET_PC, inst=0. Outputs while in reset: mem_req=0, reg_we=0, halted=0. Reset mid-MEM abandons the access; no write-back occurs.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, mem_addr={pc,0}, mem_byte_half=1.
  - On mem_ready: inst<=mem_rdata; pc<=pc+1 (wraps mod 2^PC_W); go to EXEC.
  - Without mem_ready: hold state, with no side effects.
- EXEC (always exactly 1 cycle, mem_ready ignored), in priority order:
  - halt=1: go to HALT; no register or PC update.
  - mem_re or mem_we: go to MEM; reg_we=0.
  - Otherwise: reg_we=1 and go to FETCH.
- reg_in priority: spc → {pc,0} (the already-incremented PC, i.e. the link address); ldi → sext(imm); lui → {imm, reg_o0[7:0]}; otherwise alu_out.
- alu_b: adi → sext(inst[3:0]); imm3 → zext(inst[2:0]); otherwise reg_o2.
- Branch decision (EXEC only, non-memory, non-halt instructions):
  - taken = ~cond | match, where match by cond_sel is: 00 flags[0], 01 flags[1], 10 ~flags[0], 11 ~flags[1].
  - If taken and wpc: pc<=alu_out[PC_W:1] (bit 0 dropped). wpc has priority over ipc.
  - Else if taken and ipc: pc<=pc + sext(imm[IMM_W-1:1]), relative to the incremented PC, wrapping.
  - spc combined with wpc: reg_in carries the pre-jump link value.
- MEM:
  - Outputs: mem_req=1, mem_addr=alu_out, mem_we=ctrl mem_we, mem_byte_half=inst[3].
  - Hold the state until mem_ready.
  - On mem_ready: reg_we=mem_re with reg_in=mem_rdata; go to FETCH.
  - A store asserts mem_we for every cycle of the request; memory commits it on the ready cycle.
  - If mem_re and mem_we are both set, the store wins: no register write.
- HALT: sticky until rst. Outputs: halted=1, mem_req=0, reg_we=0; pc and inst frozen.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum;
  - ctrl_flags bit index constants (CF_LDI … CF_HALT, CF_COND_SEL_LO/HI);
  - cond_sel codes (COND_Z, COND_C, COND_NZ, COND_NC).
- One sub-module, branch_unit (combinational): takes cond, cond_sel, flags, wpc, ipc, alu_out, imm and pc; produces the taken bit and next_pc.

Test Plan:
- Zero-wait fetch/execute: RESET_PC=0, mem_ready held 1, instruction ldi imm=0x80 → 2 cycles later reg_we=1, reg_in=0xFF80, pc=1.
- Wait states: mem_ready low for 3 cycles in FETCH, then in MEM during a load → state, mem_addr and inst are stable while waiting; exactly one reg_we pulse, with reg_in=mem_rdata=0xBEEF.
- Branches: pc=4 after fetch, ipc with imm=0xFA, cond=1, cond_sel=10, flags=00 → pc=1. Same instruction with flags[0]=1 → pc stays 4.
- Register jump with link: wpc, spc, alu_out=0x0120, pc=0x10 after fetch → reg_in=0x0020, pc=0x090.
- Store followed by halt: store reg_o0=0x1234 to alu_out=0x0040 → mem_we=1 and mem_wdata=0x1234 until ready, no reg_we. Next instruction has halt → halted=1, mem_req=0 for 10 or more cycles.
- Asynchronous reset mid-MEM with RESET_PC=0x100 → mem_req drops in the same cycle, no reg_we, pc=0x100. The first fetch after release uses mem_addr=0x0200.
